// File: rtl/famicom_bus_initiator.sv
// Famicom cartridge-edge bus initiator: free-running M2, CPU cycles aligned to
// M2 periods, PPU cycles timed by a strobe counter, one command at a time.
module famicom_bus_initiator #(
  parameter int M2_PHASE_CYCLES   = 4,
  parameter int PPU_STROBE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_ppu,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  output logic        ppu_rd,
  output logic        ppu_wr,
  output logic [13:0] ppu_addr,
  output logic        ppu_not_a13,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_oe,
  input  logic [7:0]  ppu_data_in,
  input  logic        irq_n,
  output logic        irq
);

  localparam logic [8:0] PH_LAST = 9'(2 * M2_PHASE_CYCLES - 1);
  localparam logic [8:0] PH_HIGH = 9'(M2_PHASE_CYCLES);
  localparam logic [7:0] ST_LAST = 8'(PPU_STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CPU_WAIT, CPU_RUN, CPU_DONE, PPU_SETUP, PPU_STROBE, PPU_HOLD, PPU_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  ph, ph_nxt;
  logic [7:0]  strb_cnt;
  logic        irq_s1;

  // latched command
  logic        c_ppu, c_write;
  logic [15:0] c_addr;
  logic [7:0]  c_wdata;

  // command fields as seen by next-cycle outputs (an accept this edge wins)
  logic        accept;
  logic        cur_write;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;

  // next values of the registered outputs
  logic        ready_n, vld_n, m2_n, romsel_n, rw_n, coe_n, rd_n, wr_n, poe_n;
  logic [14:0] caddr_n;
  logic [7:0]  cdata_n, pdata_n;
  logic [13:0] paddr_n;

  assign accept    = cmd_valid & cmd_ready;
  assign cur_write = accept ? cmd_write : c_write;
  assign cur_addr  = accept ? cmd_addr  : c_addr;
  assign cur_wdata = accept ? cmd_wdata : c_wdata;
  assign ph_nxt    = (ph == PH_LAST) ? 9'd0 : ph + 9'd1;

  // next state: CPU cycles enter RUN only on a period boundary
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, CPU_DONE, PPU_DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          if (cmd_ppu)             state_nxt = PPU_SETUP;
          else if (ph_nxt == 9'd0) state_nxt = CPU_RUN;
          else                     state_nxt = CPU_WAIT;
        end
      end
      CPU_WAIT:   if (ph_nxt == 9'd0) state_nxt = CPU_RUN;
      CPU_RUN:    if (ph_nxt == 9'd0) state_nxt = CPU_DONE;
      PPU_SETUP:  state_nxt = PPU_STROBE;
      PPU_STROBE: if (strb_cnt == ST_LAST) state_nxt = PPU_HOLD;
      PPU_HOLD:   state_nxt = PPU_DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // next output values, derived from the state/phase of the coming cycle
  always_comb begin
    ready_n  = (state_nxt == IDLE) || (state_nxt == CPU_DONE) || (state_nxt == PPU_DONE);
    vld_n    = (state_nxt == CPU_DONE) || (state_nxt == PPU_DONE);
    m2_n     = (ph_nxt >= PH_HIGH);
    romsel_n = 1'b1;
    rw_n     = 1'b1;
    coe_n    = 1'b0;
    caddr_n  = cpu_addr;
    cdata_n  = cpu_data_out;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    poe_n    = 1'b0;
    paddr_n  = ppu_addr;
    pdata_n  = ppu_data_out;
    if (state_nxt == CPU_RUN) begin
      romsel_n = ~(cur_addr[15] & m2_n);
      rw_n     = ~cur_write;
      coe_n    = cur_write & (ph_nxt != 9'd0);
      caddr_n  = cur_addr[14:0];
      cdata_n  = cur_wdata;
    end
    // write data is held one clk after m2 falls
    if (state_nxt == CPU_DONE) coe_n = cpu_data_oe;
    if (state_nxt == PPU_SETUP) begin
      paddr_n = cur_addr[13:0];
      pdata_n = cur_wdata;
    end
    if (state_nxt == PPU_SETUP || state_nxt == PPU_STROBE || state_nxt == PPU_HOLD)
      poe_n = cur_write;
    if (state_nxt == PPU_STROBE) begin
      rd_n = cur_write;
      wr_n = ~cur_write;
    end
  end

  // state, phase counter, command latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ph           <= '0;
      strb_cnt     <= '0;
      c_ppu        <= 1'b0;
      c_write      <= 1'b0;
      c_addr       <= '0;
      c_wdata      <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      m2           <= 1'b0;
      romsel       <= 1'b1;
      cpu_rw       <= 1'b1;
      cpu_addr     <= '0;
      cpu_data_out <= '0;
      cpu_data_oe  <= 1'b0;
      ppu_rd       <= 1'b1;
      ppu_wr       <= 1'b1;
      ppu_addr     <= '0;
      ppu_not_a13  <= 1'b1;
      ppu_data_out <= '0;
      ppu_data_oe  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ph       <= ph_nxt;
      strb_cnt <= (state == PPU_STROBE) ? strb_cnt + 8'd1 : 8'd0;
      if (accept) begin
        c_ppu   <= cmd_ppu;
        c_write <= cmd_write;
        c_addr  <= cmd_addr;
        c_wdata <= cmd_wdata;
      end
      // read data capture: last m2-high clk, or last strobe clk
      if (state == CPU_RUN && !c_write && !c_ppu && ph == PH_LAST)
        rsp_rdata <= cpu_data_in;
      else if (state == PPU_STROBE && !c_write && strb_cnt == ST_LAST)
        rsp_rdata <= ppu_data_in;
      cmd_ready    <= ready_n;
      rsp_valid    <= vld_n;
      m2           <= m2_n;
      romsel       <= romsel_n;
      cpu_rw       <= rw_n;
      cpu_addr     <= caddr_n;
      cpu_data_out <= cdata_n;
      cpu_data_oe  <= coe_n;
      ppu_rd       <= rd_n;
      ppu_wr       <= wr_n;
      ppu_addr     <= paddr_n;
      ppu_not_a13  <= ~paddr_n[13];
      ppu_data_out <= pdata_n;
      ppu_data_oe  <= poe_n;
    end
  end

  // two-flop synchroniser for the cartridge /IRQ line
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1 <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq_s1 <= ~irq_n;
      irq    <= irq_s1;
    end
  end

endmodule

// File: tb/tb_famicom_bus_initiator.sv
// Directed bench for famicom_bus_initiator with P=4, S=3.
module tb_famicom_bus_initiator;
  localparam int P = 4;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_ppu = 1'b0, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2, romsel, cpu_rw, cpu_data_oe;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out, cpu_data_in = '0;
  logic        ppu_rd, ppu_wr, ppu_not_a13, ppu_data_oe;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_data_out, ppu_data_in = '0;
  logic        irq_n = 1'b1, irq;

  int errors = 0;
  int checks = 0;
  int ph_tb  = 0;

  famicom_bus_initiator #(.M2_PHASE_CYCLES(P), .PPU_STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ppu(cmd_ppu), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .m2(m2), .romsel(romsel),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in), .ppu_rd(ppu_rd),
    .ppu_wr(ppu_wr), .ppu_addr(ppu_addr), .ppu_not_a13(ppu_not_a13),
    .ppu_data_out(ppu_data_out), .ppu_data_oe(ppu_data_oe), .ppu_data_in(ppu_data_in),
    .irq_n(irq_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // advance one clk; bench tracks the expected phase of the new cycle
  task automatic step();
    @(posedge clk);
    ph_tb = rst ? 0 : ((ph_tb == 2*P-1) ? 0 : ph_tb + 1);
    #1;
  endtask

  task automatic wait_ph(input int k);
    for (int i = 0; i < 4*P && ph_tb != k; i++) step();
  endtask

  task automatic test_reset();
    logic exp_m2 [8] = '{0,0,1,1,1,1,0,0};
    rst = 1'b1;
    repeat (3) step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    checks++; if ({m2, romsel, cpu_rw, cpu_data_oe} !== 4'b0110) begin errors++; $display("FAIL rst_cpu got=%b exp=0110", {m2, romsel, cpu_rw, cpu_data_oe}); end
    checks++; if ({ppu_rd, ppu_wr, ppu_not_a13, ppu_data_oe} !== 4'b1110) begin errors++; $display("FAIL rst_ppu got=%b exp=1110", {ppu_rd, ppu_wr, ppu_not_a13, ppu_data_oe}); end
    checks++; if ({cpu_addr, ppu_addr, rsp_rdata} !== '0) begin errors++; $display("FAIL rst_regs got=%h/%h/%h exp=0", cpu_addr, ppu_addr, rsp_rdata); end
    checks++; if ({rsp_valid, irq} !== 2'b00) begin errors++; $display("FAIL rst_vld_irq got=%b exp=00", {rsp_valid, irq}); end
    rst = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got=%b exp=1", cmd_ready); end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (m2 !== exp_m2[k]) begin errors++; $display("FAIL m2_pattern k=%0d got=%b exp=%b", k, m2, exp_m2[k]); end
    end
  endtask

  task automatic test_cpu_read();
    wait_ph(2);
    cmd_valid = 1'b1; cmd_ppu = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h8000; cpu_data_in = 8'hA5;
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_pending_ready got=%b exp=0", cmd_ready); end
    wait_ph(0);
    for (int k = 0; k < 2*P; k++) begin
      checks++; if (romsel !== (k < P)) begin errors++; $display("FAIL rd_romsel ph=%0d got=%b exp=%b", k, romsel, k < P); end
      checks++; if ({m2, cpu_rw, rsp_valid} !== {k >= P, 1'b1, 1'b0}) begin errors++; $display("FAIL rd_m2_rw_vld ph=%0d got=%b", k, {m2, cpu_rw, rsp_valid}); end
      checks++; if (cpu_addr !== 15'h0000) begin errors++; $display("FAIL rd_addr got=%h exp=0000", cpu_addr); end
      step();
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got=%h exp=a5", rsp_rdata); end
    checks++; if (romsel !== 1'b1) begin errors++; $display("FAIL rd_done_romsel got=%b exp=1", romsel); end
    cpu_data_in = 8'h00;
    step();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rd_after got=%b exp=01", {rsp_valid, cmd_ready}); end
    checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata_hold got=%h exp=a5", rsp_rdata); end
  endtask

  task automatic test_cpu_write();
    wait_ph(5);
    cmd_valid = 1'b1; cmd_ppu = 1'b0; cmd_write = 1'b1; cmd_addr = 16'h6000; cmd_wdata = 8'h3C;
    step();
    cmd_valid = 1'b0;
    wait_ph(0);
    for (int k = 0; k < 2*P; k++) begin
      checks++; if ({romsel, cpu_rw} !== 2'b10) begin errors++; $display("FAIL wr_romsel_rw ph=%0d got=%b exp=10", k, {romsel, cpu_rw}); end
      checks++; if (cpu_data_oe !== (k != 0)) begin errors++; $display("FAIL wr_oe ph=%0d got=%b exp=%b", k, cpu_data_oe, k != 0); end
      checks++; if (cpu_addr !== 15'h6000) begin errors++; $display("FAIL wr_addr got=%h exp=6000", cpu_addr); end
      if (k != 0) begin
        checks++; if (cpu_data_out !== 8'h3C) begin errors++; $display("FAIL wr_data got=%h exp=3c", cpu_data_out); end
      end
      step();
    end
    checks++; if ({rsp_valid, cpu_rw, cpu_data_oe} !== 3'b111) begin errors++; $display("FAIL wr_done got=%b exp=111", {rsp_valid, cpu_rw, cpu_data_oe}); end
    step();
    checks++; if ({rsp_valid, cpu_data_oe} !== 2'b00) begin errors++; $display("FAIL wr_after got=%b exp=00", {rsp_valid, cpu_data_oe}); end
    checks++; if (cpu_addr !== 15'h6000) begin errors++; $display("FAIL wr_addr_hold got=%h exp=6000", cpu_addr); end
    checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata_keep got=%h exp=a5", rsp_rdata); end
  endtask

  // cycle c=1 is SETUP, 2..S+1 STROBE, S+2 HOLD, S+3 DONE
  task automatic test_ppu(input logic wr, input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ppu_ready_idle got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_ppu = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; ppu_data_in = 8'h5A;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= S+3; c++) begin
      logic strb;
      strb = (c >= 2 && c <= S+1);
      checks++; if (ppu_rd !== !(strb && !wr)) begin errors++; $display("FAIL ppu_rd c=%0d got=%b exp=%b", c, ppu_rd, !(strb && !wr)); end
      checks++; if (ppu_wr !== !(strb && wr)) begin errors++; $display("FAIL ppu_wr c=%0d got=%b exp=%b", c, ppu_wr, !(strb && wr)); end
      checks++; if (ppu_data_oe !== (wr && c <= S+2)) begin errors++; $display("FAIL ppu_oe c=%0d got=%b exp=%b", c, ppu_data_oe, wr && c <= S+2); end
      checks++; if (rsp_valid !== (c == S+3)) begin errors++; $display("FAIL ppu_vld c=%0d got=%b exp=%b", c, rsp_valid, c == S+3); end
      checks++; if ({ppu_addr, ppu_not_a13} !== {a[13:0], ~a[13]}) begin errors++; $display("FAIL ppu_addr c=%0d got=%h/%b exp=%h", c, ppu_addr, ppu_not_a13, a[13:0]); end
      checks++; if (cpu_rw !== 1'b1) begin errors++; $display("FAIL ppu_cpu_rw c=%0d got=%b exp=1", c, cpu_rw); end
      if (wr) begin
        checks++; if (ppu_data_out !== d) begin errors++; $display("FAIL ppu_dout c=%0d got=%h exp=%h", c, ppu_data_out, d); end
      end
      if (c < S+3) step();
    end
    checks++; if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL ppu_rdata got=%h exp=%h", rsp_rdata, exp_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    wait_ph(1);
    cmd_valid = 1'b1; cmd_ppu = 1'b0; cmd_write = 1'b1; cmd_addr = 16'h7001; cmd_wdata = 8'h11;
    step();
    cmd_wdata = 8'h22;
    for (int t = 1; t <= 31; t++) begin
      logic run, done;
      run  = (t >= 7 && t <= 14) || (t >= 23 && t <= 30);
      done = (t == 15) || (t == 31);
      checks++; if (cpu_rw !== !run) begin errors++; $display("FAIL b2b_rw t=%0d got=%b exp=%b", t, cpu_rw, !run); end
      checks++; if (cmd_ready !== done) begin errors++; $display("FAIL b2b_ready t=%0d got=%b exp=%b", t, cmd_ready, done); end
      checks++; if (rsp_valid !== done) begin errors++; $display("FAIL b2b_vld t=%0d got=%b exp=%b", t, rsp_valid, done); end
      if (t == 8 || t == 24) begin
        checks++; if (cpu_data_out !== ((t == 8) ? 8'h11 : 8'h22)) begin errors++; $display("FAIL b2b_data t=%0d got=%h", t, cpu_data_out); end
      end
      step();
      if (t == 15) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    wait_ph(7);
    cmd_valid = 1'b1; cmd_ppu = 1'b0; cmd_write = 1'b1; cmd_addr = 16'h6123; cmd_wdata = 8'h77;
    step();
    cmd_valid = 1'b0;
    checks++; if ({cpu_rw, cpu_data_oe} !== 2'b00) begin errors++; $display("FAIL rm_run_ph0 got=%b exp=00", {cpu_rw, cpu_data_oe}); end
    wait_ph(5);
    checks++; if ({cpu_rw, cpu_data_oe, m2} !== 3'b011) begin errors++; $display("FAIL rm_ph5 got=%b exp=011", {cpu_rw, cpu_data_oe, m2}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({cpu_rw, cpu_data_oe, m2, romsel} !== 4'b1001) begin errors++; $display("FAIL rm_after got=%b exp=1001", {cpu_rw, cpu_data_oe, m2, romsel}); end
    checks++; if ({rsp_valid, cmd_ready} !== 2'b00) begin errors++; $display("FAIL rm_vld_ready got=%b exp=00", {rsp_valid, cmd_ready}); end
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if ({rsp_valid, cpu_rw} !== 2'b01) begin errors++; $display("FAIL rm_quiet k=%0d got=%b exp=01", k, {rsp_valid, cpu_rw}); end
    end
  endtask

  task automatic test_irq();
    irq_n = 1'b0;
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_1clk got=%b exp=0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_2clk got=%b exp=1", irq); end
    irq_n = 1'b1;
    step(); step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_release got=%b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_ppu(1'b0, 16'h2400, 8'h00, 8'h5A);
    test_ppu(1'b1, 16'h0123, 8'h99, 8'h5A);
    test_back_to_back();
    test_reset_mid();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/famicom_bus_initiator.md
Name: famicom_bus_initiator

Overview:
Console-side master for the Famicom cartridge edge. It turns single-byte command requests into correctly timed CPU-bus cycles (m2, romsel, R/W, address, data) and PPU-bus cycles (/RD, /WR, A13 and /A13, address, data). It serves the programmer/dumper board and the cartridge bring-up bench, where no real console drives the slot. M2 runs continuously, as on a console, so cartridge logic clocked by m2 keeps running between commands.

Parameters:
M2_PHASE_CYCLES, 4, clk cycles per M2 half-period (P); M2 period = 2P; legal range 2..255
PPU_STROBE_CYCLES, 3, clk cycles /RD or /WR is held low (S); legal range 1..255

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_ppu  in  1  0 = CPU cycle, 1 = PPU cycle
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  16  CPU: full A15..A0; PPU: bits 13..0 used
cmd_wdata  in  8  write data
rsp_valid  out  1  one-clk pulse when a command completes
rsp_rdata  out  8  data sampled by the last read; holds until the next read completes
m2  out  1  CPU phase-2 clock
romsel  out  1  /ROMSEL = ~(A15 & m2)
cpu_rw  out  1  1 = read
cpu_addr  out  15  CPU A14..A0
cpu_data_out  out  8  CPU write data
cpu_data_oe  out  1  enables the CPU data pad driver
cpu_data_in  in  8  CPU data pad input
ppu_rd  out  1  /RD, active low
ppu_wr  out  1  /WR, active low
ppu_addr  out  14  PPU A13..A0
ppu_not_a13  out  1  ~ppu_addr[13]
ppu_data_out  out  8  PPU write data
ppu_data_oe  out  1  enables the PPU data pad driver
ppu_data_in  in  8  PPU data pad input
irq_n  in  1  cartridge /IRQ, asynchronous
irq  out  1  synchronised, active-high IRQ

Behaviour:
- All outputs are registered. In the timing below, "ph=k" means the clk cycle during which the phase counter equals k.
- Reset values: ph=0, m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_oe=0, ppu_rd=1, ppu_wr=1, ppu_addr=0, ppu_not_a13=1, ppu_data_oe=0, rsp_valid=0, rsp_rdata=0, irq=0, cmd_ready=0. cmd_ready rises the clk after rst falls.
- Reset mid-command aborts the command, returns all signals to their reset values and produces no rsp_valid.
- Phase counter ph counts 0..2P-1 and wraps freely, independent of commands.
  - m2=0 for ph<P; m2=1 for ph>=P.
  - romsel=0 only when m2=1 and the active CPU command has A15=1; otherwise romsel=1.
- Command register holds one command.
  - cmd_ready = ~pending & ~active.
  - A command accepted with cmd_valid & cmd_ready is latched and sets pending.
  - Commands are serialised; CPU and PPU cycles never overlap.
- CPU cycle states: IDLE -> WAIT_BOUNDARY -> RUN -> DONE.
  - A pending CPU command starts at the next ph=0, never mid-period. Latency from accept to ph=0 is 1..2P clks.
  - RUN spans ph=0..2P-1:
    - cpu_addr = cmd_addr[14:0].
    - cpu_rw = ~cmd_write.
    - For writes, cpu_data_out = cmd_wdata and cpu_data_oe=1 from ph=1.
  - Reads: cpu_data_in is sampled into rsp_rdata at ph=2P-1, the last clk of m2 high.
  - DONE is the following ph=0:
    - rsp_valid=1.
    - cpu_rw returns to 1.
    - cpu_data_oe stays 1 this clk only (one-clk write hold after m2 falls), then 0.
    - cpu_addr holds its last value.
  - A back-to-back command accepted in DONE starts at the following ph=0, so one idle M2 period separates commands.
  - Idle periods: rw=1, romsel=1, m2 keeps toggling.
- PPU cycle states: IDLE -> SETUP(1 clk) -> STROBE(S clks) -> HOLD(1 clk) -> DONE(1 clk).
  - A PPU cycle starts the clk after accept and is not aligned to m2.
  - SETUP: ppu_addr and ppu_not_a13 are driven; for writes, ppu_data_oe=1.
  - STROBE: ppu_rd=0 (read) or ppu_wr=0 (write). Reads sample ppu_data_in into rsp_rdata on the last STROBE clk.
  - HOLD: strobe returns high; address and data are held.
  - DONE: rsp_valid=1 and ppu_data_oe=0.
  - ppu_rd and ppu_wr are never low together.
- irq = ~irq_n through a 2-flop synchroniser, giving 2-clk latency.

Test Plan:
1. Reset, P=4 -> m2 pattern 0000_1111 repeating; all idle values as listed; cmd_ready=0 during rst, 1 one clk after rst falls.
2. CPU read 0x8000 with cpu_data_in=0xA5 -> romsel=0 exactly for the 4 m2-high clks; cpu_addr=0x0000; rsp_valid pulses at next ph=0 with rsp_rdata=0xA5.
3. CPU write 0x6000=0x3C -> romsel stays 1; cpu_rw=0 for 8 clks from ph=0; cpu_data_oe=1 from ph=1 through the next ph=0; cpu_data_out=0x3C.
4. PPU read 0x2400 with ppu_data_in=0x5A, S=3 -> ppu_addr=0x2400, ppu_not_a13=0; ppu_rd low for exactly 3 clks; rsp_rdata=0x5A; total 6 clks accept-to-rsp; ppu_wr stays 1.
5. Back-to-back CPU writes with cmd_valid held -> second accepted on the DONE clk; exactly one idle M2 period between the runs; cmd_ready=0 while pending or active.
6. rst asserted at ph=5 of a CPU write -> next clk: cpu_rw=1, cpu_data_oe=0, m2=0, no rsp_valid. Separately, irq_n low -> irq=1 after 2 clks.
